// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bursts of up to BURST beats.
// Optional ARB_STATS_EN macro adds saturating beat/stall counters on stat_beats / stat_stalls.
module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   input  logic               fifo_full,
   output logic               fifo_we,
   output logic [DW-1:0]      fifo_data,
   output logic               busy,
   output logic [2:0]         owner
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]        stat_beats,
   output logic [15:0]        stat_stalls
`endif
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST) + 1;

   typedef enum logic {
      IDLE,
      LOCK
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   beatCnt_q, beatCnt_d;

   logic [OW-1:0]   scanIdx;
   logic            scanHit;
   logic            ownerReq;
   logic            accept;
   logic            lastBeat;

   // Scan from owner+NREQ down to owner+1 so the nearest requester after the owner wins.
   always_comb begin
      scanHit = 1'b0;
      scanIdx = owner_q;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(owner_q) + k) % NREQ]) begin
            scanHit = 1'b1;
            scanIdx = OW'((int'(owner_q) + k) % NREQ);
         end
      end
   end

   assign ownerReq = req[owner_q];
   assign accept   = (state_q == LOCK) && ownerReq && !fifo_full;
   assign lastBeat = (beatCnt_q == CW'(BURST - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OW'(NREQ - 1);
         beatCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         beatCnt_q <= beatCnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      beatCnt_d = beatCnt_q;
      case (state_q)
         IDLE: begin
            if (scanHit) begin
               state_d   = LOCK;
               owner_d   = scanIdx;
               beatCnt_d = '0;
            end
         end
         LOCK: begin
            if (accept) begin
               beatCnt_d = beatCnt_q + 1'b1;
            end
            if (!ownerReq || (accept && lastBeat)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Full stalls the owner without releasing it; fifo_we can never coincide with full.
   always_comb begin
      gnt = '0;
      if (accept) begin
         gnt[owner_q] = 1'b1;
      end
   end

   assign fifo_we   = |gnt;
   assign fifo_data = req_data[int'(owner_q) * DW +: DW];
   assign busy      = (state_q == LOCK);
   assign owner     = 3'(owner_q);

`ifdef ARB_STATS_EN
   logic [15:0] statBeats_q, statStalls_q;
   logic        stall;

   assign stall = (state_q == LOCK) && ownerReq && fifo_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         statBeats_q  <= '0;
         statStalls_q <= '0;
      end else begin
         if (accept && (statBeats_q != 16'hFFFF)) begin
            statBeats_q <= statBeats_q + 16'd1;
         end
         if (stall && (statStalls_q != 16'hFFFF)) begin
            statStalls_q <= statStalls_q + 16'd1;
         end
      end
   end

   assign stat_beats  = statBeats_q;
   assign stat_stalls = statStalls_q;
`endif

endmodule
